// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, prefetch
// queue entry layout, default halt encoding and a PC wrap helper.
// Optional build macro FETCH_ALIGN_CHK_EN adds the ERR state.
package fetch_pkg;

    localparam int ISIZE = 32;
    localparam logic [ISIZE-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1
`ifdef FETCH_ALIGN_CHK_EN
        ,
        ERR  = 2'd2
`endif
    } fetch_state_t;

    typedef struct packed {
        logic [ISIZE-1:0] instr;
        logic [ISIZE-1:0] pc;
    } fq_entry_t;

    // Word-align an address and wrap it into a 2^mem_size byte ROM.
    function automatic logic [ISIZE-1:0] pc_wrap(input logic [ISIZE-1:0] addr,
                                                 input int unsigned mem_size);
        logic [ISIZE-1:0] mask;
        mask = {ISIZE{1'b1}} >> (ISIZE - mem_size);
        mask = mask & {{(ISIZE-2){1'b1}}, 2'b00};
        return addr & mask;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fq_entry_t. DEPTH must be a power of two so the
// pointers wrap naturally. Flush empties the queue and rewinds both pointers.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fq_entry_t     push_entry,
    output fq_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full
);

    fq_entry_t         mem_q [DEPTH];
    fq_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign head  = mem_q[head_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));

    // Next-state for pointers, occupancy and storage; flush overrides push/pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        do_push = push && (!full || do_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_entry;
                tail_d        = tail_q + PW'(1);
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers; storage is cleared so no stale entry survives reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: owns the PC, reads the combinational ROM,
// buffers words in fetch_queue and presents them to decode with valid/ready.
// Redirect flushes and reloads the PC; a halt word stops fetching.
// Optional build macro FETCH_ALIGN_CHK_EN: a misaligned redirect enters ERR
// and raises a sticky fetch_err instead of silently masking the low bits.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               Isize     = 32,
    parameter int               mem_size  = 10,
    parameter logic [Isize-1:0] RESET_PC  = '0,
    parameter int               QDEPTH    = 2,
    parameter logic [Isize-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [Isize-1:0] imem_addr,
    input  logic [Isize-1:0] imem_instr,
    input  logic             redirect,
    input  logic [Isize-1:0] redirect_pc,
    input  logic             dec_ready,
    output logic             dec_valid,
    output logic [Isize-1:0] dec_instr,
    output logic [Isize-1:0] dec_pc,
    output logic             halted,
    output logic             fetch_err
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [Isize-1:0] pc_q, pc_d;
    logic             halted_q, halted_d;
    logic             enq;
    logic             deq;
    fq_entry_t        q_head;
    fq_entry_t        q_push_entry;
    logic [CW-1:0]    q_count;
    logic             q_full;

    assign imem_addr    = pc_q;
    assign dec_valid    = (q_count != '0);
    assign dec_instr    = q_head.instr;
    assign dec_pc       = q_head.pc;
    assign halted       = halted_q;
    assign q_push_entry = '{instr: imem_instr, pc: pc_q};

    // Redirect takes the cycle: no dequeue credit and no enqueue while flushing.
    assign deq = dec_valid && dec_ready && !redirect;
    assign enq = (state_q == RUN) && !redirect && (!q_full || deq);

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (enq),
        .pop        (deq),
        .flush      (redirect),
        .push_entry (q_push_entry),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full)
    );

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d;
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // Next-state for the fetch FSM, PC and status flags.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
`ifdef FETCH_ALIGN_CHK_EN
        err_d    = err_q;
`endif
        if (redirect) begin
            halted_d = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                // PC is left alone so imem_addr stays put while in ERR.
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                state_d = RUN;
                err_d   = 1'b0;
                pc_d    = pc_wrap(redirect_pc, mem_size);
            end
`else
            state_d = RUN;
            pc_d    = pc_wrap(redirect_pc, mem_size);
`endif
        end else if (enq) begin
            if (imem_instr == HALT_WORD) begin
                // Halt word is still enqueued; PC keeps pointing at it.
                state_d  = HALT;
                halted_d = 1'b1;
            end else begin
                pc_d = pc_wrap(pc_q + Isize'(4), mem_size);
            end
        end
    end

    // Fetch FSM and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
`ifdef FETCH_ALIGN_CHK_EN
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Requester side of the instruction-memory interface for each core in the two-core MESI system.
- Owns the PC and drives the byte address into the combinational-read instruction ROM.
- Captures the returned word into a small prefetch queue and hands it to decode with a valid/ready handshake.
- Supports branch redirect/flush and stops fetching on a halt word.

Parameters:
- Isize, 32: instruction and address width.
- mem_size, 10: log2 of ROM size in bytes; PC wraps modulo 2^mem_size.
- RESET_PC, 0: PC value loaded on reset.
- QDEPTH, 2: prefetch queue entries; power of two, at least 2.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  Isize  byte address to the instruction ROM; equals the current PC.
- imem_instr  input  Isize  ROM word for imem_addr, valid in the same cycle.
- redirect  input  1  branch/jump taken; flush the queue and reload the PC.
- redirect_pc  input  Isize  new PC when redirect is high.
- dec_ready  input  1  decode accepts the head entry.
- dec_valid  output  1  queue non-empty.
- dec_instr  output  Isize  head-entry instruction.
- dec_pc  output  Isize  head-entry PC.
- halted  output  1  halt word fetched; fetch stopped.
- fetch_err  output  1  misaligned redirect (only with FETCH_ALIGN_CHK_EN; otherwise tied to 0).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC; queue count, head and tail = 0.
  - dec_valid = 0; dec_instr/dec_pc = 0; halted = 0; fetch_err = 0; state = RUN.
- States:
  - RUN: fetching.
  - HALT: halt word enqueued; no fetch.
  - ERR: only with FETCH_ALIGN_CHK_EN.
- Output timing:
  - imem_addr = pc, combinational from the register.
  - dec_valid = (count != 0); dec_instr/dec_pc come combinationally from the head entry.
- Dequeue: occurs when dec_valid && dec_ready. The head advances and count decrements.
- Enqueue (RUN only, no redirect): occurs when count < QDEPTH or a dequeue happens the same cycle.
  - Writes {imem_instr, pc} at the tail.
  - pc <= (pc + 4) mod 2^mem_size; bits above mem_size are zero.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Full queue with no dequeue: pc holds and imem_addr is stable.
- Halt: if the enqueued word == HALT_WORD, the word is still enqueued and delivered.
  - Next state is HALT; halted = 1; pc stays pointing at the halt word.
  - Queue drains normally in HALT.
- Redirect: highest priority, in any state.
  - Next cycle: count = 0 and head = tail = 0.
  - No enqueue and no dequeue credit that cycle, even if dec_ready is high.
  - pc <= redirect_pc with the low two bits forced to 0 and wrapped to mem_size; state <= RUN; halted <= 0.
- Latency: the first instruction after reset or redirect is valid at decode one cycle later.
  - Sustained throughput is one instruction per cycle while dec_ready = 1.
- Reset mid-operation: all state is cleared immediately (asynchronous); no partial entries remain.
- Wrap-around: fetch at pc = 2^mem_size − 4 is followed by pc = 0.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the queue, sets state ERR and raises fetch_err (sticky).
  - No fetch occurs in ERR; only reset or an aligned redirect leaves ERR and clears fetch_err.
- Undefined: the low bits are silently masked, fetch_err is tied to 0, and the ERR state is absent.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {RUN, HALT, ERR}.
  - localparam HALT_WORD default.
  - Struct fq_entry_t {instr, pc}.
- Sub-module fetch_queue: parameterised circular FIFO of fq_entry_t.
  - Inputs: push, pop, flush; outputs: head, count, full.
  - Instantiated once inside instr_fetch_unit; the PC/FSM logic stays in the top.

Test Plan:
- Reset flow: reset high 3 cycles, ROM words 0x11,0x22,0x33 at addresses 0,4,8, dec_ready = 1 → imem_addr 0,4,8,… on consecutive cycles; dec_instr 0x11 with dec_pc 0 one cycle after reset release, then 0x22 and 0x33 back-to-back.
- Backpressure: dec_ready = 0 for 5 cycles → count saturates at 2, imem_addr holds at 8, dec_instr holds 0x11; releasing dec_ready delivers 0x11, 0x22, 0x33 with no drop or duplicate.
- Redirect: redirect = 1 with redirect_pc = 0x40 while the queue is full and dec_ready = 1 → next cycle dec_valid = 0 and imem_addr = 0x40; following cycle dec_pc = 0x40; the stale 0x22 is never delivered.
- Halt: HALT_WORD at 0x0C → delivered with dec_pc 0x0C, halted = 1, imem_addr frozen at 0x0C; a later redirect to 0 clears halted and restarts fetch.
- Wrap: redirect_pc = 0x3FC with mem_size = 10 → next fetch addresses are 0x3FC then 0x000.
- FETCH_ALIGN_CHK_EN: redirect_pc = 0x42 → fetch_err = 1, dec_valid stays 0, imem_addr constant; a redirect to 0x40 clears fetch_err and resumes fetch.
